// File: rtl/alu_ctrl_seq.sv
// Registered ALU control decoder with multi-cycle MUL/DIV sequencing and pipeline stall.
// Optional illegal-op flag enabled by defining ALU_CTRL_ILLEGAL_EN.
module alu_ctrl_seq #(
  parameter int unsigned CTRL_W     = 3,
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [1:0]        ALUOp,
  input  logic [5:0]        Funct,
  output logic [CTRL_W-1:0] alu_control,
  output logic              ctrl_valid,
  output logic              stall,
  output logic              mdu_start,
  output logic              mdu_op,
  output logic              illegal_op
);

  localparam int unsigned MaxCycles = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = (MaxCycles > 2) ? $clog2(MaxCycles) : 1;

  localparam logic [CntW-1:0] MulLoad = CntW'(MUL_CYCLES - 2);
  localparam logic [CntW-1:0] DivLoad = CntW'(DIV_CYCLES - 2);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [2:0] CodeAnd = 3'b000;
  localparam logic [2:0] CodeOr  = 3'b001;
  localparam logic [2:0] CodeAdd = 3'b010;
  localparam logic [2:0] CodeSub = 3'b100;
  localparam logic [2:0] CodeMul = 3'b101;
  localparam logic [2:0] CodeSlt = 3'b110;
  localparam logic [2:0] CodeDiv = 3'b111;

  logic [1:0]        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2:0]        code_q, code_d;
  logic [CTRL_W-1:0] alu_control_q, alu_control_d;
  logic              ctrl_valid_q, ctrl_valid_d;
  logic              mdu_start_q, mdu_start_d;
  logic              mdu_op_q, mdu_op_d;

  logic [2:0] dec_code;
  logic       dec_multi;
  logic       dec_div;
  logic       accept;

  always_comb begin
    dec_code  = CodeAdd;
    dec_multi = 1'b0;
    dec_div   = 1'b0;
    case (ALUOp)
      2'b01: dec_code = CodeSub;
      2'b10: begin
        case (Funct)
          6'b100000: dec_code = CodeAdd;
          6'b100010: dec_code = CodeSub;
          6'b100100: dec_code = CodeAnd;
          6'b100101: dec_code = CodeOr;
          6'b101010: dec_code = CodeSlt;
          6'b011100: begin
            dec_code  = CodeMul;
            dec_multi = 1'b1;
          end
          6'b011010: begin
            dec_code  = CodeDiv;
            dec_multi = 1'b1;
            dec_div   = 1'b1;
          end
          default: dec_code = CodeAdd;
        endcase
      end
      default: dec_code = CodeAdd;
    endcase
  end

  // Inputs are only consumed in IDLE or DONE; BUSY ignores in_valid entirely.
  assign accept = in_valid && ((state_q == StIdle) || (state_q == StDone));
  assign stall  = (state_q == StBusy) || (accept && dec_multi);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    code_d        = code_q;
    alu_control_d = alu_control_q;
    ctrl_valid_d  = 1'b0;
    mdu_start_d   = 1'b0;
    mdu_op_d      = mdu_op_q;
    case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (in_valid) begin
          if (dec_multi) begin
            state_d     = StBusy;
            code_d      = dec_code;
            cnt_d       = dec_div ? DivLoad : MulLoad;
            mdu_start_d = 1'b1;
            mdu_op_d    = dec_div;
          end else begin
            ctrl_valid_d  = 1'b1;
            alu_control_d = CTRL_W'(dec_code);
          end
        end
      end
      StBusy: begin
        if (cnt_q == '0) begin
          state_d       = StDone;
          ctrl_valid_d  = 1'b1;
          alu_control_d = CTRL_W'(code_q);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      code_q        <= '0;
      alu_control_q <= '0;
      ctrl_valid_q  <= 1'b0;
      mdu_start_q   <= 1'b0;
      mdu_op_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      code_q        <= code_d;
      alu_control_q <= alu_control_d;
      ctrl_valid_q  <= ctrl_valid_d;
      mdu_start_q   <= mdu_start_d;
      mdu_op_q      <= mdu_op_d;
    end
  end

  assign alu_control = alu_control_q;
  assign ctrl_valid  = ctrl_valid_q;
  assign mdu_start   = mdu_start_q;
  assign mdu_op      = mdu_op_q;

`ifdef ALU_CTRL_ILLEGAL_EN
  logic dec_illegal;
  logic illegal_q;

  always_comb begin
    dec_illegal = 1'b0;
    if (ALUOp == 2'b11) begin
      dec_illegal = 1'b1;
    end else if (ALUOp == 2'b10) begin
      case (Funct)
        6'b100000, 6'b100010, 6'b100100, 6'b100101,
        6'b101010, 6'b011100, 6'b011010: dec_illegal = 1'b0;
        default:                         dec_illegal = 1'b1;
      endcase
    end
  end

  // Illegal ops always decode as single-cycle ADD, so the flag lines up with ctrl_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= accept && dec_illegal;
    end
  end

  assign illegal_op = illegal_q;
`else
  assign illegal_op = 1'b0;
`endif

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Scoreboard bench for alu_ctrl_seq: driver queues expected results, a monitor checks them.
module tb_alu_ctrl_seq;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [1:0] ALUOp;
  logic [5:0] Funct;
  logic [2:0] alu_control;
  logic       ctrl_valid;
  logic       stall;
  logic       mdu_start;
  logic       mdu_op;
  logic       illegal_op;

`ifdef ALU_CTRL_ILLEGAL_EN
  localparam logic Ill = 1'b1;
`else
  localparam logic Ill = 1'b0;
`endif

  typedef struct {
    logic [2:0] code;
    logic       ill;
    int         cyc;
  } exp_t;

  typedef struct {
    logic op;
    int   cyc;
  } mdu_t;

  exp_t exp_q[$];
  mdu_t mdu_q[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  alu_ctrl_seq #(
    .CTRL_W    (3),
    .MUL_CYCLES(4),
    .DIV_CYCLES(32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .ALUOp      (ALUOp),
    .Funct      (Funct),
    .alu_control(alu_control),
    .ctrl_valid (ctrl_valid),
    .stall      (stall),
    .mdu_start  (mdu_start),
    .mdu_op     (mdu_op),
    .illegal_op (illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every result or MDU start must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    mdu_t m;
    if (ctrl_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ctrl_valid cyc=%0d alu_control=%b", cyc, alu_control);
      end else begin
        e = exp_q.pop_front();
        if (alu_control !== e.code || illegal_op !== e.ill || cyc != e.cyc) begin
          errors++;
          $display("FAIL result got code=%b ill=%b cyc=%0d want code=%b ill=%b cyc=%0d",
                   alu_control, illegal_op, cyc, e.code, e.ill, e.cyc);
        end
      end
    end else if (illegal_op !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL illegal_without_valid cyc=%0d got %b want 0", cyc, illegal_op);
    end
    if (mdu_start === 1'b1) begin
      checks++;
      if (mdu_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_mdu_start cyc=%0d mdu_op=%b", cyc, mdu_op);
      end else begin
        m = mdu_q.pop_front();
        if (mdu_op !== m.op || cyc != m.cyc) begin
          errors++;
          $display("FAIL mdu_start got op=%b cyc=%0d want op=%b cyc=%0d",
                   mdu_op, cyc, m.op, m.cyc);
        end
      end
    end
  end

  task automatic check1(input string name, input logic [7:0] act, input logic [7:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %b want %b", name, act, want);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check1({name, "_alu_control"}, {5'd0, alu_control}, 8'd0);
    check1({name, "_ctrl_valid"}, {7'd0, ctrl_valid}, 8'd0);
    check1({name, "_mdu_start"}, {7'd0, mdu_start}, 8'd0);
    check1({name, "_mdu_op"}, {7'd0, mdu_op}, 8'd0);
    check1({name, "_illegal_op"}, {7'd0, illegal_op}, 8'd0);
    check1({name, "_stall"}, {7'd0, stall}, 8'd0);
  endtask

  // Present an op in IDLE/DONE and queue its result n cycles after acceptance.
  task automatic issue(input logic [1:0] op, input logic [5:0] fn, input logic [2:0] code,
                       input logic ill, input int n);
    @(negedge clk);
    in_valid = 1'b1;
    ALUOp    = op;
    Funct    = fn;
    exp_q.push_back('{code: code, ill: ill, cyc: cyc + n});
    if (n > 1) mdu_q.push_back('{op: (code == 3'b111), cyc: cyc + 1});
    #1;
    check1("stall_at_accept", {7'd0, stall}, (n > 1) ? 8'd1 : 8'd0);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b1;
    in_valid = 1'b0;
    ALUOp    = 2'b00;
    Funct    = 6'b000000;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_init");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check1("stall_after_release", {7'd0, stall}, 8'd0);

    // Back-to-back single-cycle R-type ops.
    issue(2'b10, 6'b100000, 3'b010, 1'b0, 1);
    issue(2'b10, 6'b100010, 3'b100, 1'b0, 1);
    issue(2'b10, 6'b101010, 3'b110, 1'b0, 1);
    issue(2'b10, 6'b100100, 3'b000, 1'b0, 1);
    issue(2'b10, 6'b100101, 3'b001, 1'b0, 1);
    idle();

    // MUL, then an ADD presented during DONE.
    issue(2'b10, 6'b011100, 3'b101, 1'b0, 4);
    for (int k = 0; k < 3; k++) begin
      idle();
      #1;
      check1("stall_mul_busy", {7'd0, stall}, 8'd1);
    end
    issue(2'b00, 6'b000000, 3'b010, 1'b0, 1);
    repeat (3) idle();

    // DIV with inputs held through BUSY; released before DONE.
    issue(2'b10, 6'b011010, 3'b111, 1'b0, 32);
    for (int k = 0; k < 31; k++) begin
      @(negedge clk);
      #1;
      check1("stall_div_busy", {7'd0, stall}, 8'd1);
    end
    idle();
    repeat (3) idle();

    // Unknown and non-R-type classes.
    issue(2'b10, 6'b111111, 3'b010, Ill, 1);
    issue(2'b00, 6'b101010, 3'b010, 1'b0, 1);
    issue(2'b01, 6'b100000, 3'b100, 1'b0, 1);
    issue(2'b11, 6'b100010, 3'b010, Ill, 1);
    idle();
    repeat (2) idle();

    // DIV aborted by reset; its result must never appear.
    @(negedge clk);
    in_valid = 1'b1;
    ALUOp    = 2'b10;
    Funct    = 6'b011010;
    mdu_q.push_back('{op: 1'b1, cyc: cyc + 1});
    #1;
    check1("stall_div_abort_accept", {7'd0, stall}, 8'd1);
    repeat (10) idle();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid_div");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) idle();
    issue(2'b00, 6'b000000, 3'b010, 1'b0, 1);
    repeat (4) idle();

    check1("results_pending", 8'(exp_q.size()), 8'd0);
    check1("mdu_pending", 8'(mdu_q.size()), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_seq.md
Name: alu_ctrl_seq

Overview:
- Parametrised, registered successor to the combinational ALU control decoder.
- Decodes ALUOp/Funct into an ALU control code and issues it with a valid strobe.
- Adds multi-cycle sequencing for MUL and DIV: starts the multiply/divide unit, stalls the pipeline for a programmable number of cycles, then issues the result control.
- Sits between the main control unit and the ALU/MDU in the execute stage.

Parameters:
- CTRL_W, 3, width of alu_control; must be >= 3; codes are zero-extended into the upper bits.
- MUL_CYCLES, 4, cycles from MUL acceptance to its ctrl_valid; must be >= 2.
- DIV_CYCLES, 32, cycles from DIV acceptance to its ctrl_valid; must be >= 2.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  ALUOp/Funct valid this cycle.
- ALUOp  in  2  operation class from the main control unit.
- Funct  in  6  R-type function field.
- alu_control  out  CTRL_W  registered ALU control code.
- ctrl_valid  out  1  alu_control valid; single-cycle pulse per accepted op.
- stall  out  1  combinational; upstream must hold its instruction.
- mdu_start  out  1  registered; 1-cycle start pulse to the multiply/divide unit.
- mdu_op  out  1  registered; 0 = MUL, 1 = DIV; valid with mdu_start.
- illegal_op  out  1  registered; see Optional Feature.

Behaviour:
- Reset (rst_n = 0, asynchronous): state = IDLE, counter = 0, alu_control = 0, ctrl_valid = 0, mdu_start = 0, mdu_op = 0, illegal_op = 0.
- Decode, by ALUOp:
  - 00 → ADD 010.
  - 01 → SUB 100.
  - 11 → ADD 010.
  - 10 → by Funct: 100000 ADD 010; 100010 SUB 100; 100100 AND 000; 100101 OR 001; 101010 SLT 110; 011100 MUL 101; 011010 DIV 111; any other → ADD 010 (unknown).
- MUL and DIV are multi-cycle; everything else is single-cycle.
- States: IDLE, BUSY, DONE.
- IDLE or DONE with in_valid = 1:
  - Single-cycle op: ctrl_valid = 1 and alu_control = code on the next cycle; state becomes IDLE. Back-to-back single-cycle ops issue one per cycle.
  - Multi-cycle op: latch code; counter = N-2 (N = MUL_CYCLES or DIV_CYCLES); mdu_start = 1 and mdu_op set on the next cycle; go to BUSY.
- BUSY: counter decrements each cycle. At counter == 0 go to DONE. in_valid is ignored.
- DONE: lasts exactly one cycle; ctrl_valid = 1 with the latched code. A new op may be accepted in the same cycle, as in IDLE.
- Result timing: for an op accepted at edge T, ctrl_valid is high in the cycle after edge T+N-1, i.e. N cycles after acceptance (N = 1 for single-cycle ops).
- stall = (state == BUSY) OR ((state == IDLE or DONE) AND in_valid AND op is multi-cycle).
- ctrl_valid, mdu_start and illegal_op are 0 in every cycle not specified above.
- alu_control holds its last value when ctrl_valid = 0.
- in_valid = 0 in IDLE or DONE: go to IDLE, no outputs.
- Counter width = $clog2(max(MUL_CYCLES, DIV_CYCLES)); it never wraps because it is reloaded only on acceptance.
- Reset mid-BUSY: immediate return to IDLE; the pending result is discarded and no ctrl_valid is produced.

Optional Feature:
- Macro: ALU_CTRL_ILLEGAL_EN.
- Defined: an ALUOp = 10 op with unknown Funct still issues ADD 010 with ctrl_valid, and illegal_op = 1 in that same cycle. ALUOp = 11 also raises illegal_op.
- Undefined: illegal_op is tied to 0; unknown ops silently default to ADD.

Test Plan:
- Reset: assert rst_n = 0 mid-cycle → all outputs 0 immediately, state IDLE; release → stall = 0.
- Back-to-back single-cycle ops: ALUOp = 10 with Funct 100000, 100010, 101010, 100100 on four consecutive cycles → alu_control = 010, 100, 110, 000 with ctrl_valid = 1 on cycles +1..+4; stall stays 0.
- MUL, MUL_CYCLES = 4: issue MUL → stall = 1 for 4 cycles starting with the acceptance cycle; mdu_start = 1 and mdu_op = 0 at +1; ctrl_valid = 1 with alu_control = 101 at +4; a queued ADD presented during DONE issues at +5.
- DIV, DIV_CYCLES = 32: issue DIV with in_valid held high throughout → exactly one ctrl_valid, with alu_control = 111 at +32; mdu_op = 1; held inputs during BUSY are not double-accepted.
- Reset mid-op: issue DIV, assert rst_n = 0 at +10 → ctrl_valid never asserted for that DIV; an ADD after reset release issues normally at +1.
- Unknown op: ALUOp = 10, Funct = 111111 → alu_control = 010, ctrl_valid = 1; illegal_op = 1 only with ALU_CTRL_ILLEGAL_EN, otherwise 0. ALUOp = 00 and 01 → 010 and 100, illegal_op = 0.
